// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for mem_bus_arbiter: FSM states, port owner codes and
// constants used by the arbiter and its optional timeout counter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } arb_owner_t;

    // Fetches always read the whole word.
    localparam logic [3:0] SEL_WORD = 4'hF;
    // Width of the BUSY-cycle watchdog counter.
    localparam int TCNT_W = 16;

endpackage

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// mem_arb_timeout_cnt: counts BUSY cycles of the arbiter and flags the cycle
// in which the count reaches LIMIT. Only built with MEM_ARB_TIMEOUT_EN; in
// the default build this file is empty so no unused module is elaborated.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_timeout_cnt
    import mem_bus_arbiter_pkg::*;
#(
    parameter int LIMIT = 255
)(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic busy,
    output logic expire
);

    // Value held during the LIMIT-th BUSY cycle (count starts at 0).
    localparam logic [TCNT_W-1:0] LAST = TCNT_W'(LIMIT - 1);

    logic [TCNT_W-1:0] cnt;

    // Clear on the granting edge, then count every BUSY cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       cnt <= '0;
        else if (clear) cnt <= '0;
        else if (busy)  cnt <= cnt + TCNT_W'(1);
    end

    assign expire = busy && (cnt == LAST);

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port RAM between the fetch port and the
// load/store port. Data has fixed priority; one access at a time runs a
// req/ack handshake to the RAM and returns a one-cycle ack to its owner.
// Optional feature: MEM_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts an
// access after TIMEOUT_CYCLES and raises a sticky timeout_o.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_req_i,
    input  logic [AW-1:0] inst_addr_i,
    output logic [DW-1:0] inst_rdata_o,
    output logic          inst_ack_o,
    input  logic          data_req_i,
    input  logic          data_we_i,
    input  logic [3:0]    data_sel_i,
    input  logic [AW-1:0] data_addr_i,
    input  logic [DW-1:0] data_wdata_i,
    output logic [DW-1:0] data_rdata_o,
    output logic          data_ack_o,
    output logic          ram_req_o,
    output logic          ram_we_o,
    output logic [3:0]    ram_sel_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_rdata_i,
    input  logic          ram_ack_i,
    output logic          stallreq_o,
    output logic          timeout_o
);

    arb_state_t state, state_nxt;
    arb_owner_t owner;
    logic       grant;
    logic       expire;
    logic       done;

    // Illegal settings leave an empty, named block as a marker for reviewers.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout_cycles
    end

    assign grant = data_req_i | inst_req_i;
    // An access leaves BUSY on the RAM ack or on watchdog expiry.
    assign done  = ram_ack_i | expire;

`ifdef MEM_ARB_TIMEOUT_EN
    logic timeout_q;

    mem_arb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == ARB_IDLE && grant),
        .busy   (state == ARB_BUSY),
        .expire (expire)
    );

    // Sticky until reset; an ack in the expiry cycle wins over the timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                           timeout_q <= 1'b0;
        else if (state == ARB_BUSY && expire && !ram_ack_i) timeout_q <= 1'b1;
    end

    assign timeout_o = timeout_q;
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ARB_IDLE;
        else      state <= state_nxt;
    end

    // Next state: RESP always returns to IDLE so a held request is not re-granted.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (grant) state_nxt = ARB_BUSY;
            ARB_BUSY: if (done)  state_nxt = ARB_RESP;
            ARB_RESP: state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    // Grant, RAM command latch and read-data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner        <= OWN_NONE;
            ram_req_o    <= 1'b0;
            ram_we_o     <= 1'b0;
            ram_sel_o    <= '0;
            ram_addr_o   <= '0;
            ram_wdata_o  <= '0;
            inst_rdata_o <= '0;
            data_rdata_o <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (data_req_i) begin
                        owner       <= OWN_DATA;
                        ram_req_o   <= 1'b1;
                        ram_we_o    <= data_we_i;
                        ram_sel_o   <= data_sel_i;
                        ram_addr_o  <= data_addr_i;
                        ram_wdata_o <= data_wdata_i;
                    end else if (inst_req_i) begin
                        owner       <= OWN_INST;
                        ram_req_o   <= 1'b1;
                        ram_we_o    <= 1'b0;
                        ram_sel_o   <= SEL_WORD;
                        ram_addr_o  <= inst_addr_i;
                        ram_wdata_o <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (done) begin
                        ram_req_o <= 1'b0;
                        // A timed-out access returns zero instead of bus junk.
                        if (owner == OWN_DATA) data_rdata_o <= ram_ack_i ? ram_rdata_i : '0;
                        else                   inst_rdata_o <= ram_ack_i ? ram_rdata_i : '0;
                    end
                end
                ARB_RESP: owner <= OWN_NONE;
                default:  owner <= OWN_NONE;
            endcase
        end
    end

    assign inst_ack_o = (state == ARB_RESP) && (owner == OWN_INST);
    assign data_ack_o = (state == ARB_RESP) && (owner == OWN_DATA);
    assign stallreq_o = (inst_req_i & ~inst_ack_o) | (data_req_i & ~data_ack_o);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter. A transaction-level model predicts,
// per cycle, when the RAM is requested, which port owns it, when each ack
// pulses and what each port's rdata holds. Covers priority, random RAM
// latency, stores, illegal req drops, spurious RAM acks, async reset in
// BUSY and the never-acking RAM (timeout or persistent stall).
module tb_mem_bus_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int TO_CYC = 8;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inst_req_i, data_req_i, data_we_i, ram_ack_i;
    logic [AW-1:0] inst_addr_i, data_addr_i;
    logic [3:0]    data_sel_i;
    logic [DW-1:0] data_wdata_i, ram_rdata_i;
    logic [DW-1:0] inst_rdata_o, data_rdata_o, ram_wdata_o;
    logic [AW-1:0] ram_addr_o;
    logic [3:0]    ram_sel_o;
    logic          inst_ack_o, data_ack_o, ram_req_o, ram_we_o, stallreq_o, timeout_o;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .rst(rst_n),
        .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
        .inst_rdata_o(inst_rdata_o), .inst_ack_o(inst_ack_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_sel_i(data_sel_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rdata_o(data_rdata_o), .data_ack_o(data_ack_o),
        .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i), .ram_ack_i(ram_ack_i),
        .stallreq_o(stallreq_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Model: one access window [acc_start, acc_end] of RAM request cycles,
    // ack in cycle acc_end+1, next grant no earlier than edge acc_end+3.
    int          cyc, free_edge, acc_start, acc_end, ack_iv, acc_own;
    bit          acc_on, never_ack, no_new, inst_only, exp_to;
    logic        a_we;
    logic [3:0]  a_sel;
    logic [31:0] a_addr, a_wdata, a_val, exp_irdata, exp_drdata;
    bit          pend [2];
    int          gap  [2];

    task automatic model_edge();
        logic [31:0] v;
        cyc++;
        if (acc_on && cyc == acc_end + 1) begin
            v = never_ack ? 32'h0 : a_val;
            if (acc_own == 2) exp_drdata = v;
            else              exp_irdata = v;
            if (never_ack) exp_to = 1'b1;
            acc_on    = 1'b0;
            ack_iv    = cyc;
            free_edge = cyc + 2;
        end
        if (!acc_on && cyc >= free_edge && (data_req_i || inst_req_i)) begin
            acc_on    = 1'b1;
            acc_start = cyc;
            acc_own   = data_req_i ? 2 : 1;
            if (data_req_i) begin
                a_we = data_we_i; a_sel = data_sel_i; a_addr = data_addr_i; a_wdata = data_wdata_i;
            end else begin
                a_we = 1'b0; a_sel = 4'hF; a_addr = inst_addr_i; a_wdata = 32'h0;
            end
            a_val = $urandom;
            if (never_ack) acc_end = cyc + (TO_EN ? TO_CYC - 1 : 1000000);
            else           acc_end = cyc + int'($urandom_range(0, TO_CYC - 1));
        end
    endtask

    task automatic check_iv();
        bit ia, da;
        ia = (ack_iv == cyc) && (acc_own == 1);
        da = (ack_iv == cyc) && (acc_own == 2);
        chk("ram_req", 32'(ram_req_o), 32'(acc_on));
        if (acc_on) begin
            chk("ram_we", 32'(ram_we_o), 32'(a_we));
            chk("ram_sel", 32'(ram_sel_o), 32'(a_sel));
            chk("ram_addr", ram_addr_o, a_addr);
            if (acc_own == 2) chk("ram_wdata", ram_wdata_o, a_wdata);
        end
        chk("inst_ack", 32'(inst_ack_o), 32'(ia));
        chk("data_ack", 32'(data_ack_o), 32'(da));
        chk("inst_rdata", inst_rdata_o, exp_irdata);
        chk("data_rdata", data_rdata_o, exp_drdata);
        chk("stallreq", 32'(stallreq_o), 32'((inst_req_i & ~ia) | (data_req_i & ~da)));
        chk("timeout", 32'(timeout_o), 32'(exp_to));
    endtask

    task automatic drive_iv();
        for (int p = 0; p < 2; p++) begin
            if (ack_iv == cyc && acc_own == p + 1) begin
                pend[p] = 1'b0;
                gap[p]  = int'($urandom_range(0, 3));
                if (p == 0) inst_req_i = 1'b0; else data_req_i = 1'b0;
            end else if (!pend[p]) begin
                if (gap[p] > 0) gap[p]--;
                else if (!no_new && (!inst_only || p == 0) && $urandom_range(0, 1) == 1) begin
                    pend[p] = 1'b1;
                    if (p == 0) begin
                        inst_req_i  = 1'b1;
                        inst_addr_i = 32'($urandom_range(0, 255)) << 2;
                    end else begin
                        data_req_i   = 1'b1;
                        data_we_i    = 1'($urandom_range(0, 1));
                        data_sel_i   = 4'($urandom_range(1, 15));
                        data_addr_i  = 32'($urandom_range(0, 255)) << 2;
                        data_wdata_i = $urandom;
                    end
                end
            end else if (acc_on && acc_own == p + 1 && $urandom_range(0, 15) == 0) begin
                // illegal drop while owned: access must still complete
                if (p == 0) inst_req_i = 1'b0; else data_req_i = 1'b0;
            end
        end
        ram_ack_i   = acc_on && !never_ack && (cyc == acc_end);
        ram_rdata_i = ram_ack_i ? a_val : $urandom;
        if (!acc_on && $urandom_range(0, 4) == 0) ram_ack_i = 1'b1;  // must be ignored
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_iv();
            drive_iv();
        end
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, then releases.
    task automatic do_reset(input int hold);
        inst_req_i = 1'b0; data_req_i = 1'b0; ram_ack_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_ram_req", 32'(ram_req_o), 32'h0);
        chk("rst_ram_we", 32'(ram_we_o), 32'h0);
        chk("rst_ram_sel", 32'(ram_sel_o), 32'h0);
        chk("rst_ram_addr", ram_addr_o, 32'h0);
        chk("rst_ram_wdata", ram_wdata_o, 32'h0);
        chk("rst_acks", 32'({inst_ack_o, data_ack_o}), 32'h0);
        chk("rst_inst_rdata", inst_rdata_o, 32'h0);
        chk("rst_data_rdata", data_rdata_o, 32'h0);
        chk("rst_timeout", 32'(timeout_o), 32'h0);
        chk("rst_stallreq", 32'(stallreq_o), 32'h0);
        acc_on = 1'b0; free_edge = 0; ack_iv = -1; acc_own = 0;
        exp_irdata = 32'h0; exp_drdata = 32'h0; exp_to = 1'b0;
        for (int p = 0; p < 2; p++) begin pend[p] = 1'b0; gap[p] = 0; end
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst_n = 1'b1;
        inst_req_i = 1'b0; inst_addr_i = '0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_sel_i = '0; data_addr_i = '0; data_wdata_i = '0;
        ram_ack_i = 1'b0; ram_rdata_i = '0;
        cyc = 0; never_ack = 1'b0; no_new = 1'b0; inst_only = 1'b0;
        #2;
        do_reset(3);

        run(800);

        // reset while an access is in flight
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            run(1);
            found = acc_on;
        end
        chk("busy_reached", 32'(found), 32'h1);
        do_reset(2);
        run(300);

        // drain, then a RAM that never acks
        no_new = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            run(1);
            found = !acc_on && !pend[0] && !pend[1];
        end
        chk("drained", 32'(found), 32'h1);
        run(2);
        no_new = 1'b0; inst_only = 1'b1; never_ack = 1'b1;
        run(40);
        do_reset(2);
        no_new = 1'b0; inst_only = 1'b0; never_ack = 1'b0;
        run(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
